// File: rtl/sdp_array_banked_pkg.sv
// Shared defaults and SRAM macro tie-offs
// for the banked simple-dual-port array.
package sdp_array_banked_pkg;

  localparam int WIDTH_DEF     = 768;
  localparam int SDP_WIDTH_DEF = 32;
  localparam int DEPTH_DEF     = 4096;
  localparam int SDP_DEPTH_DEF = 2048;

  typedef struct packed {
    logic [2:0] ema;
    logic [1:0] emaw;
    logic       emas;
    logic       test1;
    logic       se;
    logic       ret1n;
    logic       coll_det;
  } macro_tie_t;

  // Test/scan off, retention off, macro collision logic off
  localparam macro_tie_t MACRO_TIE = '{
    ema:      3'b010,
    emaw:     2'b01,
    emas:     1'b0,
    test1:    1'b0,
    se:       1'b0,
    ret1n:    1'b1,
    coll_det: 1'b0
  };

endpackage

// File: rtl/sdp_array_banked_macro_wrap.sv
// One SDP macro: active-high enables mapped to
// active-low pins, plus a behavioural array model.
module sdp_macro_wrap
  import sdp_array_banked_pkg::*;
#(
  parameter  int W  = SDP_WIDTH_DEF,
  parameter  int D  = SDP_DEPTH_DEF,
  localparam int AW = $clog2(D)
)(
  input  logic          clk,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  output logic [W-1:0]  rd_data_o
);

  logic         cena_n;
  logic         cenb_n;
  logic [W-1:0] bwenb_n;
  macro_tie_t   tie;
  logic         tie_ok;

  assign cena_n  = ~rd_en_i;
  assign cenb_n  = ~wr_en_i;
  assign bwenb_n = '0;
  assign tie     = MACRO_TIE;
  assign tie_ok  = (tie == MACRO_TIE);

  logic [W-1:0] mem [D];
  logic [W-1:0] q_q;

  // Read-before-write: a same-row read sees old data
  always_ff @(posedge clk) begin
    if (!cenb_n && tie_ok)
      mem[wr_addr_i] <= (mem[wr_addr_i] & bwenb_n)
                      | (wr_data_i & ~bwenb_n);
    if (!cena_n && tie_ok)
      q_q <= mem[rd_addr_i];
  end

  assign rd_data_o = q_q;

endmodule

// File: rtl/sdp_array_banked.sv
// Banked SDP array: bank/column macro grid,
// write-to-read forwarding, optional output stage.
module sdp_array_banked
  import sdp_array_banked_pkg::*;
#(
  parameter  int WIDTH     = WIDTH_DEF,
  parameter  int SDP_WIDTH = SDP_WIDTH_DEF,
  parameter  int DEPTH     = DEPTH_DEF,
  parameter  int SDP_DEPTH = SDP_DEPTH_DEF,
  parameter  int OUT_REG   = 1,
  localparam int NUM_COL   = WIDTH / SDP_WIDTH,
  localparam int NUM_BANK  = DEPTH / SDP_DEPTH,
  localparam int AW        = $clog2(DEPTH),
  localparam int BW        = $clog2(SDP_DEPTH),
  localparam int LAT       = 1 + OUT_REG
)(
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              wr_en,
  input  logic [AW-1:0]                     wr_addr,
  input  logic [NUM_COL-1:0]                wr_mask,
  input  logic [NUM_COL-1:0][SDP_WIDTH-1:0] wr_data,
  input  logic                              rd_en,
  input  logic [AW-1:0]                     rd_addr,
  output logic [NUM_COL-1:0][SDP_WIDTH-1:0] rd_data,
  output logic                              rd_valid,
  output logic                              rd_coll
);

  localparam int BKW = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;

  typedef logic [NUM_COL-1:0][SDP_WIDTH-1:0] word_t;

  if (WIDTH % SDP_WIDTH != 0) begin : g_chk_w
    $error("WIDTH must be a multiple of SDP_WIDTH");
  end
  if (DEPTH % SDP_DEPTH != 0) begin : g_chk_d
    $error("DEPTH must be a multiple of SDP_DEPTH");
  end
  if ((NUM_BANK & (NUM_BANK - 1)) != 0) begin : g_chk_b
    $error("NUM_BANK must be a power of two");
  end
  if (OUT_REG != 0 && OUT_REG != 1) begin : g_chk_o
    $error("OUT_REG must be 0 or 1");
  end
  if (LAT < 1) begin : g_chk_l
    $error("bad LAT");
  end

  logic           live_q, live_d;
  logic           rd_ok, wr_ok, coll;
  logic [BKW-1:0] rd_bank, wr_bank;
  logic [BW-1:0]  rd_row, wr_row;

  // First request is taken one edge after reset release
  assign rd_ok   = rd_en & live_q;
  assign wr_ok   = wr_en & live_q & (|wr_mask);
  assign coll    = rd_ok & wr_ok & (rd_addr == wr_addr);
  assign rd_bank = BKW'(rd_addr >> BW);
  assign wr_bank = BKW'(wr_addr >> BW);
  assign rd_row  = rd_addr[BW-1:0];
  assign wr_row  = wr_addr[BW-1:0];

  logic [SDP_WIDTH-1:0] mac_rd [NUM_BANK][NUM_COL];

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
      sdp_macro_wrap #(
        .W (SDP_WIDTH),
        .D (SDP_DEPTH)
      ) u_mac (
        .clk       (clk),
        .rd_en_i   (rd_ok && rd_bank == BKW'(b)),
        .rd_addr_i (rd_row),
        .wr_en_i   (wr_ok && wr_bank == BKW'(b) && wr_mask[c]),
        .wr_addr_i (wr_row),
        .wr_data_i (wr_data[c]),
        .rd_data_o (mac_rd[b][c])
      );
    end
  end

  logic               v1_q, v1_d;
  logic               coll1_q, coll1_d;
  logic [BKW-1:0]     bank1_q, bank1_d;
  logic [NUM_COL-1:0] fmask1_q, fmask1_d;
  word_t              fdata1_q, fdata1_d;
  word_t              d1;

  always_comb begin
    live_d   = 1'b1;
    v1_d     = rd_ok;
    coll1_d  = coll;
    bank1_d  = rd_ok ? rd_bank : bank1_q;
    fmask1_d = coll ? wr_mask : '0;
    fdata1_d = coll ? wr_data : fdata1_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      live_q   <= 1'b0;
      v1_q     <= 1'b0;
      coll1_q  <= 1'b0;
      bank1_q  <= '0;
      fmask1_q <= '0;
      fdata1_q <= '0;
    end else begin
      live_q   <= live_d;
      v1_q     <= v1_d;
      coll1_q  <= coll1_d;
      bank1_q  <= bank1_d;
      fmask1_q <= fmask1_d;
      fdata1_q <= fdata1_d;
    end
  end

  always_comb begin
    d1 = '0;
    for (int c = 0; c < NUM_COL; c++)
      d1[c] = fmask1_q[c] ? fdata1_q[c]
                          : mac_rd[bank1_q][c];
  end

  if (OUT_REG == 1) begin : g_oreg
    logic  v2_q, v2_d;
    logic  coll2_q, coll2_d;
    word_t data2_q, data2_d;

    always_comb begin
      v2_d    = v1_q;
      coll2_d = v1_q & coll1_q;
      data2_d = v1_q ? d1 : data2_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        v2_q    <= 1'b0;
        coll2_q <= 1'b0;
        data2_q <= '0;
      end else begin
        v2_q    <= v2_d;
        coll2_q <= coll2_d;
        data2_q <= data2_d;
      end
    end

    assign rd_valid = v2_q;
    assign rd_coll  = coll2_q;
    assign rd_data  = data2_q;
  end else begin : g_noreg
    word_t hold_q, hold_d;

    always_comb begin
      hold_d = v1_q ? d1 : hold_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) hold_q <= '0;
      else       hold_q <= hold_d;
    end

    assign rd_valid = v1_q;
    assign rd_coll  = v1_q & coll1_q;
    assign rd_data  = v1_q ? d1 : hold_q;
  end

endmodule

// File: tb/tb_sdp_array_banked.sv
// Directed bench: OUT_REG=1 and OUT_REG=0 instances
// driven in lockstep and checked at their latencies.
module tb_sdp_array_banked;

  localparam int DW = 768;
  localparam int NC = 24;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [NC-1:0] wr_mask;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd0, rd1;
  logic          rv0, rv1, rc0, rc1;

  always #5 clk = ~clk;

  sdp_array_banked #(.OUT_REG(1)) u_dut1 (
    .clk(clk), .rstn(rstn),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_mask(wr_mask), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd1), .rd_valid(rv1), .rd_coll(rc1)
  );

  sdp_array_banked #(.OUT_REG(0)) u_dut0 (
    .clk(clk), .rstn(rstn),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_mask(wr_mask), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd0), .rd_valid(rv0), .rd_coll(rc0)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [NC-1:0] wm;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic          ec;
    logic [DW-1:0] ed;
  } vec_t;

  localparam int NV = 21;
  vec_t v [NV];

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] h0 = '0;
  logic [DW-1:0] h1 = '0;

  function automatic logic [DW-1:0] rep(input logic [7:0] b);
    return {96{b}};
  endfunction

  function automatic vec_t mk(
    input logic we, input logic [AW-1:0] wa,
    input logic [NC-1:0] wm, input logic [DW-1:0] wd,
    input logic re, input logic [AW-1:0] ra,
    input logic ec, input logic [DW-1:0] ed);
    vec_t r;
    r.we = we; r.wa = wa; r.wm = wm; r.wd = wd;
    r.re = re; r.ra = ra; r.ec = ec; r.ed = ed;
    return r;
  endfunction

  task automatic cmp(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk(input int d, input string nm,
                     input logic ev, input logic ec,
                     input logic [DW-1:0] ed);
    string p;
    p = $sformatf("%s.oreg%0d", nm, d);
    if (d == 1) begin
      if (ev) h1 = ed;
      cmp({p, ".valid"}, DW'(rv1), DW'(ev));
      cmp({p, ".coll"},  DW'(rc1), DW'(ev & ec));
      cmp({p, ".data"},  rd1, h1);
    end else begin
      if (ev) h0 = ed;
      cmp({p, ".valid"}, DW'(rv0), DW'(ev));
      cmp({p, ".coll"},  DW'(rc0), DW'(ev & ec));
      cmp({p, ".data"},  rd0, h0);
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = '0; wr_mask = '0; wr_data = '0;
    rd_en = 0; rd_addr = '0;
  endtask

  task automatic drive(input vec_t x);
    wr_en = x.we; wr_addr = x.wa;
    wr_mask = x.wm; wr_data = x.wd;
    rd_en = x.re; rd_addr = x.ra;
  endtask

  // Single read, both instances checked at own latency
  task automatic do_read(input string nm,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] ed);
    idle();
    rd_en = 1; rd_addr = a;
    @(negedge clk);
    idle();
    chk(0, nm, 1'b1, 1'b0, ed);
    @(negedge clk);
    chk(1, nm, 1'b1, 1'b0, ed);
  endtask

  logic [DW-1:0] e_col0, e_mix, e_b, all1;
  localparam logic [NC-1:0] FULL = '1;

  initial begin
    all1   = '1;
    e_col0 = '0;
    e_col0[31:0] = 32'hFFFF_FFFF;
    e_mix  = rep(8'h22);
    e_mix[63:0] = {8{8'h11}};
    e_b    = '0;

    v[0]  = mk(1, 5,    FULL, rep(8'hA5), 0, 0,    0, e_b);
    v[1]  = mk(0, 0,    '0,   e_b,        1, 5,    0, rep(8'hA5));
    v[2]  = mk(1, 10,   FULL, rep(8'h10), 0, 0,    0, e_b);
    v[3]  = mk(1, 2058, FULL, rep(8'h20), 0, 0,    0, e_b);
    v[4]  = mk(1, 7,    FULL, e_b,        0, 0,    0, e_b);
    v[5]  = mk(1, 9,    FULL, rep(8'h22), 0, 0,    0, e_b);
    v[6]  = mk(0, 0,    '0,   e_b,        1, 10,   0, rep(8'h10));
    v[7]  = mk(0, 0,    '0,   e_b,        1, 2058, 0, rep(8'h20));
    v[8]  = mk(0, 0,    '0,   e_b,        1, 10,   0, rep(8'h10));
    v[9]  = mk(0, 0,    '0,   e_b,        1, 2058, 0, rep(8'h20));
    v[10] = mk(1, 7,    24'h1, all1,      0, 0,    0, e_b);
    v[11] = mk(0, 0,    '0,   e_b,        1, 7,    0, e_col0);
    v[12] = mk(1, 9,    24'h3, rep(8'h11), 1, 9,   1, e_mix);
    v[13] = mk(0, 0,    '0,   e_b,        1, 9,    0, e_mix);
    v[14] = mk(1, 2058, '0,   all1,       1, 2058, 0, rep(8'h20));
    v[15] = mk(0, 0,    '0,   e_b,        1, 2058, 0, rep(8'h20));
    v[16] = mk(1, 10,   FULL, rep(8'h33), 1, 2058, 0, rep(8'h20));
    v[17] = mk(1, 5,    FULL, rep(8'h44), 1, 5,    1, rep(8'h44));
    v[18] = mk(0, 0,    '0,   e_b,        1, 10,   0, rep(8'h33));
    v[19] = mk(1, 2053, FULL, rep(8'h66), 1, 5,    0, rep(8'h44));
    v[20] = mk(0, 0,    '0,   e_b,        1, 2053, 0, rep(8'h66));

    rstn = 0;
    idle();
    repeat (2) @(negedge clk);
    chk(0, "reset", 1'b0, 1'b0, e_b);
    chk(1, "reset", 1'b0, 1'b0, e_b);
    rstn = 1;
    @(negedge clk);

    for (int i = 0; i < NV + 2; i++) begin
      if (i < NV) drive(v[i]);
      else        idle();
      @(negedge clk);
      if (i < NV)
        chk(0, $sformatf("vec%0d", i), v[i].re, v[i].ec, v[i].ed);
      if (i >= 1 && i <= NV)
        chk(1, $sformatf("vec%0d", i - 1),
            v[i-1].re, v[i-1].ec, v[i-1].ed);
    end

    // Two reads in flight, then reset before OUT_REG=1 valid
    idle();
    rd_en = 1; rd_addr = 5;
    @(negedge clk);
    rd_addr = 10;
    rstn = 0;
    @(negedge clk);
    h0 = '0; h1 = '0;
    chk(0, "in_reset", 1'b0, 1'b0, e_b);
    chk(1, "in_reset", 1'b0, 1'b0, e_b);
    @(negedge clk);
    // Requests in the release cycle must be ignored
    rstn = 1;
    idle();
    rd_en = 1; rd_addr = 5;
    wr_en = 1; wr_addr = 5; wr_mask = FULL; wr_data = rep(8'hEE);
    @(negedge clk);
    idle();
    for (int k = 0; k < 3; k++) begin
      chk(0, $sformatf("post_rst%0d", k), 1'b0, 1'b0, e_b);
      chk(1, $sformatf("post_rst%0d", k), 1'b0, 1'b0, e_b);
      @(negedge clk);
    end
    do_read("reread5", 5, rep(8'h44));
    do_read("reread10", 10, rep(8'h33));
    do_read("reread9", 9, e_mix);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sdp_array_banked.md
SDP_ARRAY_BANKED -- requirements
Module: sdp_array_banked

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  WIDTH 768, total data width in bits
  SDP_WIDTH 32, data width of one SRAM macro
  DEPTH 4096, total words
  SDP_DEPTH 2048, words per macro
  OUT_REG 1, extra output register stage (0 or 1)
REQ-002 Derived: NUM_COL=WIDTH/SDP_WIDTH, NUM_BANK=DEPTH/SDP_DEPTH, AW=$clog2(DEPTH), BW=$clog2(SDP_DEPTH), LAT=1+OUT_REG.
REQ-003 Ports (name direction width meaning) SHALL be:
  clk  in  1  single clock for both ports
  rstn  in  1  reset, asynchronous, active-low
  wr_en  in  1  write request
  wr_addr  in  AW  write word address
  wr_mask  in  NUM_COL  per-column write enable, 1 = write
  wr_data  in  NUM_COL x SDP_WIDTH  write data
  rd_en  in  1  read request
  rd_addr  in  AW  read word address
  rd_data  out  NUM_COL x SDP_WIDTH  read data
  rd_valid  out  1  rd_data valid this cycle
  rd_coll  out  1  returned word was forwarded from a same-cycle write
REQ-004 One clock; reset asynchronous and active-low, ports named clk and rstn.

Function
REQ-005 Storage SHALL be NUM_BANK x NUM_COL macros; bank = addr[AW-1:BW], macro row address = addr[BW-1:0].
REQ-006 A write SHALL enable only macros of the addressed bank, and within it only columns with wr_mask=1; masked-off columns keep contents.
REQ-007 wr_en with wr_mask all-zero SHALL leave memory unchanged.
REQ-008 A read SHALL enable only the addressed bank's macros; other banks stay deselected (power).
REQ-009 rd_valid SHALL assert exactly LAT cycles after rd_en sampled high, one cycle per request; back-to-back reads every cycle SHALL yield back-to-back valids.
REQ-010 Bank select SHALL be pipelined with the request so rd_data muxes the correct bank even when consecutive reads alternate banks.
REQ-011 Write and read to different addresses in one cycle SHALL both complete; read returns pre-write contents of its address.
REQ-012 Same-cycle write and read to the same address (collision): rd_data SHALL return wr_data for columns with wr_mask=1 and old contents for others; rd_coll SHALL assert with that rd_valid.
REQ-013 Macro collision detection SHALL be disabled; forwarding in REQ-012 is the sole collision mechanism.
REQ-014 When rd_valid=0, rd_data SHALL hold its last value; rd_coll SHALL be 0.
REQ-015 A read one cycle after a write to the same address SHALL return the new data (write-then-read ordering guaranteed).
REQ-016 Elaboration SHALL fail if WIDTH%SDP_WIDTH!=0, DEPTH%SDP_DEPTH!=0, NUM_BANK not power of two, or OUT_REG not in {0,1}.

Reset
REQ-017 While rstn=0: rd_valid=0, rd_coll=0, rd_data=0, all pipeline valid/bank/forward registers cleared.
REQ-018 Reset SHALL NOT clear memory contents.
REQ-019 Reads in flight when rstn asserts SHALL be discarded; no rd_valid after release for them.
REQ-020 Requests SHALL be ignored in the cycle rstn deasserts; first accepted on the next edge.

Structure
REQ-021 Shared package SHALL hold default WIDTH/SDP_WIDTH/DEPTH/SDP_DEPTH constants and the macro tie-off values (EMA settings, test/scan inputs inactive, retention off).
REQ-022 One sub-module, sdp_macro_wrap, SHALL map active-high enables/mask to one active-low macro instance (or behavioural model in simulation) with all tie-offs.
REQ-023 Bank/column arrays SHALL be generate loops; forwarding and output pipeline in top module.

Verification
REQ-024 Defaults, OUT_REG=1: write 0xA5.. to addr 5, read addr 5 next cycle -> rd_valid 2 cycles after rd_en, data 0xA5.., rd_coll=0.
REQ-025 Alternate reads addr 10 (bank0) and 2058 (bank1) every cycle, preloaded distinct -> continuous rd_valid, correct data per order.
REQ-026 Write addr 7 mask 0x000001 data all-1 over all-0 contents -> read returns column0 all-1, other columns 0.
REQ-027 Same cycle write addr 9 mask 0x3 data 0x11.. and read addr 9 (old 0x22..) -> columns0-1 = 0x11.., others 0x22.., rd_coll=1.
REQ-028 Issue 2 reads, assert rstn=0 before valids -> no rd_valid, rd_data=0; memory intact on re-read after release.
REQ-029 Repeat REQ-024 and REQ-027 with OUT_REG=0 -> latency 1 cycle, same data.
